// File: rtl/bp_me_stream_cmd_arbiter_pkg.sv
// Shared helpers for the BedRock stream command arbiter.
// Round-robin pointer arithmetic used by the arbiter FSM.
package bp_me_stream_cmd_arbiter_pkg;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bp_me_stream_cmd_arbiter_picker.sv
// Rotate-priority picker: first set request at or above ptr_i,
// wrapping past the top index; one-hot grant plus its index.
module bp_me_rr_picker #(
  parameter int num_src_p = 2
) (
  input  logic [num_src_p-1:0]         req_i,
  input  logic [$clog2(num_src_p)-1:0] ptr_i,
  output logic [num_src_p-1:0]         grant_o,
  output logic [$clog2(num_src_p)-1:0] idx_o,
  output logic                         v_o
);

  localparam int idx_w = $clog2(num_src_p);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    v_o     = 1'b0;
    j       = 0;
    for (int i = 0; i < num_src_p; i++) begin
      j = int'(ptr_i) + i;
      if (j >= num_src_p) j = j - num_src_p;
      if (!v_o && req_i[j]) begin
        v_o        = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = idx_w'(j);
      end
    end
  end

endmodule

// File: rtl/bp_me_stream_cmd_arbiter.sv
// Round-robin arbiter sharing one BedRock stream command channel;
// a source keeps the grant from its first presented beat to its last.
import bp_me_stream_cmd_arbiter_pkg::*;

module bp_me_stream_cmd_arbiter #(
  parameter int num_src_p      = 2,
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_src_p*header_width_p-1:0] src_header_i,
  input  logic [num_src_p*data_width_p-1:0]   src_data_i,
  input  logic [num_src_p-1:0]                src_v_i,
  input  logic [num_src_p-1:0]                src_last_i,
  output logic [num_src_p-1:0]                src_ready_and_o,
  output logic [header_width_p-1:0]           mem_cmd_header_o,
  output logic [data_width_p-1:0]             mem_cmd_data_o,
  output logic                                mem_cmd_v_o,
  output logic                                mem_cmd_last_o,
  input  logic                                mem_cmd_ready_and_i,
  output logic [num_src_p-1:0]                grant_o
);

  localparam int idx_w = $clog2(num_src_p);

  typedef enum logic {
    e_idle,
    e_locked
  } state_e;

  state_e               state_q, state_d;
  logic [num_src_p-1:0] grant_q, grant_d;
  logic [idx_w-1:0]     rr_ptr_q, rr_ptr_d;

  logic [num_src_p-1:0] pick_oh;
  logic [idx_w-1:0]     pick_idx;
  logic                 pick_v;
  logic [idx_w-1:0]     lock_idx;
  logic [num_src_p-1:0] sel_oh;
  logic [idx_w-1:0]     sel_idx;
  logic                 hs_last;

  bp_me_rr_picker #(
    .num_src_p(num_src_p)
  ) picker (
    .req_i  (src_v_i),
    .ptr_i  (rr_ptr_q),
    .grant_o(pick_oh),
    .idx_o  (pick_idx),
    .v_o    (pick_v)
  );

  always_comb begin
    lock_idx = '0;
    for (int k = 0; k < num_src_p; k++)
      if (grant_q[k]) lock_idx = idx_w'(k);
  end

  // Once locked, the registered grant alone steers the mux.
  assign sel_oh  = (state_q == e_locked) ? grant_q : pick_oh;
  assign sel_idx = (state_q == e_locked) ? lock_idx : pick_idx;

  always_comb begin
    mem_cmd_v_o      = 1'b0;
    mem_cmd_last_o   = 1'b0;
    mem_cmd_header_o = '0;
    mem_cmd_data_o   = '0;
    for (int k = 0; k < num_src_p; k++) begin
      mem_cmd_v_o      |= sel_oh[k] & src_v_i[k];
      mem_cmd_last_o   |= sel_oh[k] & src_last_i[k];
      mem_cmd_header_o |= {header_width_p{sel_oh[k]}}
                        & src_header_i[k*header_width_p +: header_width_p];
      mem_cmd_data_o   |= {data_width_p{sel_oh[k]}}
                        & src_data_i[k*data_width_p +: data_width_p];
    end
  end

  assign src_ready_and_o = sel_oh & {num_src_p{mem_cmd_ready_and_i}};
  assign grant_o         = sel_oh;
  assign hs_last = mem_cmd_v_o & mem_cmd_ready_and_i & mem_cmd_last_o;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      e_idle: begin
        if (pick_v) begin
          if (hs_last) begin
            rr_ptr_d = idx_w'(rr_next(32'(pick_idx), num_src_p));
          end else begin
            state_d = e_locked;
            grant_d = pick_oh;
          end
        end
      end
      e_locked: begin
        if (hs_last) begin
          state_d  = e_idle;
          grant_d  = '0;
          rr_ptr_d = idx_w'(rr_next(32'(sel_idx), num_src_p));
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // A granted source must hold valid until its last beat.
  a_lock_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == e_locked) |-> |(src_v_i & grant_q))
    else $error("granted source dropped valid mid-message");

endmodule

// File: tb/tb_bp_me_stream_cmd_arbiter.sv
// Testbench: vector table on a 2-source arbiter, directed and
// randomized checks on a 3-source arbiter against a reference model.
module tb_bp_me_stream_cmd_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // two-source instance
  logic        a_rst;
  logic [31:0] a_hdr, a_dat;
  logic [1:0]  a_v, a_last, a_srdy, a_grant;
  logic [15:0] a_oh, a_od;
  logic        a_ov, a_olast, a_ready;

  bp_me_stream_cmd_arbiter #(
    .num_src_p(2), .header_width_p(16), .data_width_p(16)
  ) dut_a (
    .clk_i(clk), .reset_i(a_rst),
    .src_header_i(a_hdr), .src_data_i(a_dat),
    .src_v_i(a_v), .src_last_i(a_last),
    .src_ready_and_o(a_srdy),
    .mem_cmd_header_o(a_oh), .mem_cmd_data_o(a_od),
    .mem_cmd_v_o(a_ov), .mem_cmd_last_o(a_olast),
    .mem_cmd_ready_and_i(a_ready), .grant_o(a_grant)
  );

  // three-source instance
  logic        b_rst;
  logic [47:0] b_hdr, b_dat;
  logic [2:0]  b_v, b_last, b_srdy, b_grant;
  logic [15:0] b_oh, b_od;
  logic        b_ov, b_olast, b_ready;

  bp_me_stream_cmd_arbiter #(
    .num_src_p(3), .header_width_p(16), .data_width_p(16)
  ) dut_b (
    .clk_i(clk), .reset_i(b_rst),
    .src_header_i(b_hdr), .src_data_i(b_dat),
    .src_v_i(b_v), .src_last_i(b_last),
    .src_ready_and_o(b_srdy),
    .mem_cmd_header_o(b_oh), .mem_cmd_data_o(b_od),
    .mem_cmd_v_o(b_ov), .mem_cmd_last_o(b_olast),
    .mem_cmd_ready_and_i(b_ready), .grant_o(b_grant)
  );

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [1:0] last;
    logic       rdy;
    logic [15:0] d0;
    logic [15:0] d1;
    logic       ev;
    logic       elast;
    logic [1:0] eg;
    logic [1:0] er;
    logic [15:0] ed;
  } vec_t;

  vec_t tv[$];

  task automatic step_b(input logic [2:0] v, input logic [2:0] eg,
                        input string name);
    @(negedge clk);
    b_v = v; b_last = v; b_ready = 1'b1;
    #1;
    chk({name, "_grant"}, 64'(b_grant), 64'(eg));
    chk({name, "_ready"}, 64'(b_srdy), 64'(eg));
    chk({name, "_v"}, 64'(b_ov), 64'(|eg));
  endtask

  int act[3], len[3], beat[3], msg[3];
  int owner, ptr, g;
  logic [39:0] exp_pk, act_pk;
  logic [15:0] s_dat[3], s_hdr[3];
  logic [15:0] eh;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1'b1; a_v = '0; a_last = '0; a_ready = 1'b1;
    a_hdr = {16'hC001, 16'hC000}; a_dat = '0;
    b_rst = 1'b1; b_v = '0; b_last = '0; b_ready = 1'b1;
    b_hdr = {16'hB002, 16'hB001, 16'hB000};
    b_dat = {16'h2002, 16'h2001, 16'h2000};

    // rst v last rdy d0 d1 | ev elast eg er ed
    tv.push_back('{1, 2'b00, 2'b00, 1, 16'h0000, 16'h0000, 0, 0, 2'b00, 2'b00, 16'h0000});
    tv.push_back('{0, 2'b01, 2'b01, 1, 16'h0100, 16'h0000, 1, 1, 2'b01, 2'b01, 16'h0100});
    tv.push_back('{0, 2'b01, 2'b00, 1, 16'h0201, 16'h0000, 1, 0, 2'b01, 2'b01, 16'h0201});
    tv.push_back('{0, 2'b11, 2'b10, 1, 16'h0202, 16'h1201, 1, 0, 2'b01, 2'b01, 16'h0202});
    tv.push_back('{0, 2'b11, 2'b10, 1, 16'h0203, 16'h1201, 1, 0, 2'b01, 2'b01, 16'h0203});
    tv.push_back('{0, 2'b11, 2'b11, 1, 16'h0204, 16'h1201, 1, 1, 2'b01, 2'b01, 16'h0204});
    tv.push_back('{0, 2'b11, 2'b11, 1, 16'h0300, 16'h1201, 1, 1, 2'b10, 2'b10, 16'h1201});
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        tv.push_back('{0, 2'b11, 2'b11, 1, 16'h0300, 16'h1300, 1, 1, 2'b01, 2'b01, 16'h0300});
      else
        tv.push_back('{0, 2'b11, 2'b11, 1, 16'h0300, 16'h1300, 1, 1, 2'b10, 2'b10, 16'h1300});
    end
    tv.push_back('{0, 2'b10, 2'b10, 0, 16'h0300, 16'h1400, 1, 1, 2'b10, 2'b00, 16'h1400});
    tv.push_back('{0, 2'b11, 2'b11, 0, 16'h0400, 16'h1400, 1, 1, 2'b10, 2'b00, 16'h1400});
    tv.push_back('{0, 2'b11, 2'b11, 0, 16'h0400, 16'h1400, 1, 1, 2'b10, 2'b00, 16'h1400});
    tv.push_back('{0, 2'b11, 2'b11, 1, 16'h0400, 16'h1400, 1, 1, 2'b10, 2'b10, 16'h1400});
    tv.push_back('{0, 2'b01, 2'b01, 1, 16'h0400, 16'h0000, 1, 1, 2'b01, 2'b01, 16'h0400});
    tv.push_back('{0, 2'b01, 2'b00, 1, 16'h0501, 16'h0000, 1, 0, 2'b01, 2'b01, 16'h0501});
    tv.push_back('{1, 2'b01, 2'b00, 1, 16'h0502, 16'h0000, 1, 0, 2'b01, 2'b01, 16'h0502});
    tv.push_back('{0, 2'b00, 2'b00, 1, 16'h0000, 16'h0000, 0, 0, 2'b00, 2'b00, 16'h0000});
    tv.push_back('{0, 2'b11, 2'b11, 1, 16'h0600, 16'h1600, 1, 1, 2'b01, 2'b01, 16'h0600});
    tv.push_back('{0, 2'b11, 2'b11, 1, 16'h0601, 16'h1600, 1, 1, 2'b10, 2'b10, 16'h1600});

    repeat (3) @(posedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      a_rst = tv[i].rst; a_v = tv[i].v; a_last = tv[i].last;
      a_ready = tv[i].rdy; a_dat = {tv[i].d1, tv[i].d0};
      #1;
      eh = (tv[i].eg == 2'b01) ? 16'hC000 :
           (tv[i].eg == 2'b10) ? 16'hC001 : 16'h0000;
      chk($sformatf("a_row%0d_v", i), 64'(a_ov), 64'(tv[i].ev));
      chk($sformatf("a_row%0d_last", i), 64'(a_olast), 64'(tv[i].elast));
      chk($sformatf("a_row%0d_grant", i), 64'(a_grant), 64'(tv[i].eg));
      chk($sformatf("a_row%0d_ready", i), 64'(a_srdy), 64'(tv[i].er));
      chk($sformatf("a_row%0d_data", i), 64'(a_od), 64'(tv[i].ed));
      chk($sformatf("a_row%0d_hdr", i), 64'(a_oh), 64'(eh));
    end
    @(negedge clk);
    a_v = '0; a_last = '0;

    // three sources: wrap from pointer 2 to source 0, then rotation
    b_rst = 1'b0;
    step_b(3'b010, 3'b010, "b_first");
    step_b(3'b011, 3'b001, "b_wrap");
    chk("b_wrap_data", 64'(b_od), 64'h2000);
    step_b(3'b011, 3'b010, "b_after_wrap");
    step_b(3'b111, 3'b100, "b_rot0");
    step_b(3'b111, 3'b001, "b_rot1");
    step_b(3'b111, 3'b010, "b_rot2");
    step_b(3'b111, 3'b100, "b_rot3");

    // randomized traffic against a message-level reference model
    @(negedge clk);
    b_rst = 1'b1; b_v = '0; b_last = '0;
    @(negedge clk);
    b_rst = 1'b0;
    owner = -1; ptr = 0;
    for (int k = 0; k < 3; k++) begin
      act[k] = 0; len[k] = 1; beat[k] = 0; msg[k] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (act[k] == 0 && $urandom_range(0, 2) == 0) begin
          act[k] = 1; len[k] = $urandom_range(1, 4); beat[k] = 0;
        end
        s_dat[k] = 16'((k << 12) | ((msg[k] & 255) << 4) | beat[k]);
        s_hdr[k] = 16'((k << 12) | 16'h0800 | (msg[k] & 255));
        b_v[k] = (act[k] != 0);
        b_last[k] = (act[k] != 0) && (beat[k] == len[k] - 1);
        b_dat[k*16 +: 16] = s_dat[k];
        b_hdr[k*16 +: 16] = s_hdr[k];
      end
      b_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = owner;
      if (g < 0)
        for (int i = 0; i < 3; i++)
          if (g < 0 && act[(ptr + i) % 3] != 0) g = (ptr + i) % 3;
      if (g < 0)
        exp_pk = '0;
      else
        exp_pk = {3'(1 << g), b_ready ? 3'(1 << g) : 3'b000,
                  b_v[g], b_last[g], s_hdr[g], s_dat[g]};
      act_pk = {b_grant, b_srdy, b_ov, b_olast, b_oh, b_od};
      chk($sformatf("b_rand_cyc%0d", cyc), 64'(act_pk), 64'(exp_pk));
      if (g >= 0) begin
        if (act[g] != 0 && b_ready) begin
          if (beat[g] == len[g] - 1) begin
            owner = -1; ptr = (g + 1) % 3; act[g] = 0; msg[g]++;
          end else begin
            owner = g; beat[g]++;
          end
        end else begin
          owner = g;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
